// File: rtl/uart_frame_rx.sv
// uart_frame_rx: 8N1 UART receiver feeding a header/payload/checksum/tail
// frame parser with error codes, inter-byte timeout and good-frame counter.
module uart_frame_rx #(
   parameter int         CLK_FREQ     = 50_000_000,
   parameter int         UART_BPS     = 115200,
   parameter logic [7:0] HDR0         = 8'hFF,
   parameter logic [7:0] HDR1         = 8'h00,
   parameter logic [7:0] TAIL         = 8'hAA,
   parameter int         PAYLOAD_LEN  = 5,
   parameter int         CHK_EN       = 1,
   parameter int         TIMEOUT_BITS = 20
) (
   input  logic                     CLK_50M,
   input  logic                     rst,
   input  logic                     uart_rxd,
   output logic [7:0]               rx_byte,
   output logic                     rx_byte_valid,
   output logic [8*PAYLOAD_LEN-1:0] payload_data,
   output logic                     frame_valid,
   output logic                     frame_err,
   output logic [1:0]               err_code,
   output logic                     busy,
   output logic [15:0]              frame_cnt
);

   localparam int BPS_CNT = CLK_FREQ / UART_BPS;
   localparam int HALF    = BPS_CNT / 2;
   localparam int TMO_LIM = TIMEOUT_BITS * BPS_CNT;
   localparam int CW      = $clog2(BPS_CNT + 1);
   localparam int TW      = $clog2(TMO_LIM + 1);
   localparam int PW      = 8 * PAYLOAD_LEN;

   typedef enum logic [1:0] {
      R_IDLE, R_START, R_DATA, R_STOP
   } rstate_t;

   typedef enum logic [2:0] {
      P_HUNT0, P_HUNT1, P_PAYLOAD, P_CHK, P_TAIL
   } pstate_t;

   rstate_t       rstate;
   pstate_t       pstate;
   logic [2:0]    sync;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          fr_strobe;
   logic [4:0]    idx;
   logic [7:0]    sum;
   logic [PW-1:0] shadow;
   logic [TW-1:0] tcnt;
   logic          line;
   logic          fall;
   logic          tmo;
   logic          kill;
   logic          in_frame;

   // sync[1:0] is the two-flop synchroniser; sync[2] only feeds edge detect
   assign line = sync[1];
   assign fall = sync[2] & ~sync[1];

   always_ff @(posedge CLK_50M) begin
      if (rst) begin
         sync          <= 3'b111;
         rstate        <= R_IDLE;
         cnt           <= '0;
         bit_idx       <= '0;
         shift         <= '0;
         rx_byte       <= '0;
         rx_byte_valid <= 1'b0;
         fr_strobe     <= 1'b0;
      end else begin
         sync          <= {sync[1:0], uart_rxd};
         rx_byte_valid <= 1'b0;
         fr_strobe     <= 1'b0;
         unique case (rstate)
            R_IDLE: begin
               cnt <= '0;
               if (fall) rstate <= R_START;
            end
            R_START: begin
               if (cnt == CW'(HALF)) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  rstate  <= line ? R_IDLE : R_DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            R_DATA: begin
               if (cnt == CW'(BPS_CNT - 1)) begin
                  cnt   <= '0;
                  shift <= {line, shift[7:1]};
                  if (bit_idx == 3'd7) rstate <= R_STOP;
                  else bit_idx <= bit_idx + 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            R_STOP: begin
               if (cnt == CW'(BPS_CNT - 1)) begin
                  cnt    <= '0;
                  rstate <= R_IDLE;
                  if (line) begin
                     rx_byte       <= shift;
                     rx_byte_valid <= 1'b1;
                  end else begin
                     fr_strobe <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: rstate <= R_IDLE;
         endcase
      end
   end

   assign in_frame = (pstate == P_PAYLOAD) ||
                     (pstate == P_CHK) ||
                     (pstate == P_TAIL);
   assign tmo  = (pstate != P_HUNT0) && !rx_byte_valid &&
                 (tcnt == TW'(TMO_LIM - 1));
   assign kill = fr_strobe | tmo;

   always_ff @(posedge CLK_50M) begin
      if (rst) begin
         pstate       <= P_HUNT0;
         idx          <= '0;
         sum          <= '0;
         shadow       <= '0;
         tcnt         <= '0;
         payload_data <= '0;
         frame_valid  <= 1'b0;
         frame_err    <= 1'b0;
         err_code     <= 2'd0;
         busy         <= 1'b0;
         frame_cnt    <= '0;
      end else begin
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         if (pstate == P_HUNT0 || rx_byte_valid) tcnt <= '0;
         else tcnt <= tcnt + 1'b1;
         // busy mirrors in_frame: it is set/cleared on every entry/exit
         if (kill && in_frame) begin
            frame_err <= 1'b1;
            err_code  <= 2'd3;
            pstate    <= P_HUNT0;
            busy      <= 1'b0;
         end else if (kill && pstate == P_HUNT1) begin
            pstate <= P_HUNT0;
         end else if (rx_byte_valid) begin
            unique case (pstate)
               P_HUNT0: begin
                  if (rx_byte == HDR0) pstate <= P_HUNT1;
               end
               P_HUNT1: begin
                  if (rx_byte == HDR1) begin
                     pstate <= P_PAYLOAD;
                     busy   <= 1'b1;
                     idx    <= '0;
                     sum    <= '0;
                  end else if (rx_byte != HDR0) begin
                     pstate <= P_HUNT0;
                  end
               end
               P_PAYLOAD: begin
                  shadow <= (shadow << 8) | PW'(rx_byte);
                  sum    <= sum + rx_byte;
                  if (idx == 5'(PAYLOAD_LEN - 1))
                     pstate <= (CHK_EN != 0) ? P_CHK : P_TAIL;
                  else
                     idx <= idx + 1'b1;
               end
               P_CHK: begin
                  if (rx_byte != sum) begin
                     frame_err <= 1'b1;
                     err_code  <= 2'd1;
                     pstate    <= P_HUNT0;
                     busy      <= 1'b0;
                  end else begin
                     pstate <= P_TAIL;
                  end
               end
               P_TAIL: begin
                  pstate <= P_HUNT0;
                  busy   <= 1'b0;
                  if (rx_byte == TAIL) begin
                     payload_data <= shadow;
                     frame_valid  <= 1'b1;
                     frame_cnt    <= frame_cnt + 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                     err_code  <= 2'd2;
                  end
               end
               default: begin
                  pstate <= P_HUNT0;
                  busy   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: directed frames into two parameterisations of
// uart_frame_rx, checked against hand-computed values.
module tb_uart_frame_rx;

   localparam int BPS_A = 2_000_000 / 115200;
   localparam int BPS_B = 250_000 / 9600;
   localparam int LIM_A = 20 * BPS_A;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rxd_a = 1'b1;
   logic        rxd_b = 1'b1;

   logic [7:0]  rxb_a, rxb_b;
   logic        rxv_a, rxv_b;
   logic [39:0] pay_a;
   logic [23:0] pay_b;
   logic        fv_a, fv_b, fe_a, fe_b;
   logic [1:0]  ec_a, ec_b;
   logic        busy_a, busy_b;
   logic [15:0] fc_a, fc_b;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int n_rxv_a = 0, n_fv_a = 0, n_fe_a = 0;
   int n_rxv_b = 0, n_fv_b = 0;
   int rxv_cyc = 0, fv_cyc = 0, fe_cyc = 0;

   always #10 clk = ~clk;

   uart_frame_rx #(
      .CLK_FREQ(2_000_000), .UART_BPS(115200)
   ) dut_a (
      .CLK_50M(clk), .rst(rst), .uart_rxd(rxd_a),
      .rx_byte(rxb_a), .rx_byte_valid(rxv_a),
      .payload_data(pay_a), .frame_valid(fv_a),
      .frame_err(fe_a), .err_code(ec_a),
      .busy(busy_a), .frame_cnt(fc_a)
   );

   uart_frame_rx #(
      .CLK_FREQ(250_000), .UART_BPS(9600),
      .PAYLOAD_LEN(3), .CHK_EN(0)
   ) dut_b (
      .CLK_50M(clk), .rst(rst), .uart_rxd(rxd_b),
      .rx_byte(rxb_b), .rx_byte_valid(rxv_b),
      .payload_data(pay_b), .frame_valid(fv_b),
      .frame_err(fe_b), .err_code(ec_b),
      .busy(busy_b), .frame_cnt(fc_b)
   );

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rxv_a) begin
         n_rxv_a <= n_rxv_a + 1;
         rxv_cyc <= cyc;
      end
      if (fv_a) begin
         n_fv_a <= n_fv_a + 1;
         fv_cyc <= cyc;
      end
      if (fe_a) begin
         n_fe_a <= n_fe_a + 1;
         fe_cyc <= cyc;
      end
      if (rxv_b) n_rxv_b <= n_rxv_b + 1;
      if (fv_b) n_fv_b <= n_fv_b + 1;
   end

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic drv(input bit sel_b, input logic v);
      if (sel_b) rxd_b = v;
      else rxd_a = v;
   endtask

   task automatic send_byte(input logic [7:0] b,
                            input logic stp,
                            input bit sel_b);
      int n;
      n = sel_b ? BPS_B : BPS_A;
      drv(sel_b, 1'b0);
      repeat (n) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         drv(sel_b, b[i]);
         repeat (n) @(negedge clk);
      end
      drv(sel_b, stp);
      repeat (n) @(negedge clk);
      drv(sel_b, 1'b1);
      if (!stp) repeat (n) @(negedge clk);
   endtask

   // bytes are packed first-sent in the MSBs of the len*8 field
   task automatic send_frame(input logic [127:0] v,
                             input int len,
                             input bit sel_b);
      logic [7:0] b;
      for (int i = 0; i < len; i++) begin
         b = v[8*(len-1-i) +: 8];
         send_byte(b, 1'b1, sel_b);
      end
   endtask

   task automatic idle(input int bits);
      repeat (bits * BPS_A) @(negedge clk);
   endtask

   int r0, v0, e0, w;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_rxb", rxb_a, 0);
      chk("rst_rxv", rxv_a, 0);
      chk("rst_pay", pay_a, 0);
      chk("rst_fv", fv_a, 0);
      chk("rst_fe", fe_a, 0);
      chk("rst_ec", ec_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_fc", fc_a, 0);
      chk("rst_pay_b", pay_b, 0);
      rst = 1'b0;
      idle(2);

      // good frame
      r0 = n_rxv_a; v0 = n_fv_a; e0 = n_fe_a;
      send_frame(128'hFF003F, 3, 1'b0);
      chk("busy_mid", busy_a, 1);
      send_frame(128'h000FA08D7BAA, 6, 1'b0);
      idle(2);
      chk("g1_rxv", n_rxv_a - r0, 9);
      chk("g1_fv", n_fv_a - v0, 1);
      chk("g1_fe", n_fe_a - e0, 0);
      chk("g1_pay", pay_a, 40'h3F000FA08D);
      chk("g1_fc", fc_a, 1);
      chk("g1_lat", fv_cyc - rxv_cyc, 1);
      chk("g1_rxb", rxb_a, 8'hAA);
      chk("g1_busy", busy_a, 0);

      // bad checksum, then a different good frame
      e0 = n_fe_a; v0 = n_fv_a;
      send_frame(128'hFF003F000FA08D0A, 8, 1'b0);
      chk("ck_fe", n_fe_a - e0, 1);
      chk("ck_ec", ec_a, 1);
      send_frame(128'hAA, 1, 1'b0);
      idle(2);
      chk("ck_fv", n_fv_a - v0, 0);
      chk("ck_pay", pay_a, 40'h3F000FA08D);
      chk("ck_fc", fc_a, 1);
      send_frame(128'hFF0001020304050FAA, 9, 1'b0);
      idle(2);
      chk("g2_fv", n_fv_a - v0, 1);
      chk("g2_pay", pay_a, 40'h0102030405);
      chk("g2_fc", fc_a, 2);
      chk("g2_ec_hold", ec_a, 1);

      // repeated header byte, bad tail, resync
      e0 = n_fe_a; v0 = n_fv_a;
      send_frame(128'hFFFF003F000FA08D7B55, 10, 1'b0);
      idle(2);
      chk("tl_fe", n_fe_a - e0, 1);
      chk("tl_ec", ec_a, 2);
      chk("tl_fv", n_fv_a - v0, 0);
      chk("tl_pay", pay_a, 40'h0102030405);
      send_frame(128'hFF003F000FA08D7BAA, 9, 1'b0);
      idle(2);
      chk("g3_fv", n_fv_a - v0, 1);
      chk("g3_fc", fc_a, 3);

      // stop bit forced low on 3rd payload byte
      e0 = n_fe_a;
      send_frame(128'hFF003F00, 4, 1'b0);
      r0 = n_rxv_a;
      send_byte(8'h0F, 1'b0, 1'b0);
      idle(2);
      chk("fr_rxv", n_rxv_a - r0, 0);
      chk("fr_fe", n_fe_a - e0, 1);
      chk("fr_ec", ec_a, 3);
      chk("fr_busy", busy_a, 0);

      // set err_code to 1, then stall mid-frame for 25 bits
      send_frame(128'hFF003F000FA08D0A, 8, 1'b0);
      idle(2);
      chk("pre_ec", ec_a, 1);
      e0 = n_fe_a;
      send_frame(128'hFF003F00, 4, 1'b0);
      idle(25);
      chk("to_fe", n_fe_a - e0, 1);
      chk("to_ec", ec_a, 3);
      w = fe_cyc - rxv_cyc;
      chk("to_when", (w >= LIM_A - 1 && w <= LIM_A + 2), 1);
      chk("to_fc", fc_a, 3);

      // counter wrap
      force dut_a.frame_cnt = 16'hFFFF;
      #1;
      release dut_a.frame_cnt;
      @(negedge clk);
      chk("wr_pre", fc_a, 16'hFFFF);
      v0 = n_fv_a;
      send_frame(128'hFF0001020304050FAA, 9, 1'b0);
      idle(2);
      chk("wr_fv", n_fv_a - v0, 1);
      chk("wr_fc", fc_a, 0);

      // reset in the middle of a payload
      v0 = n_fv_a; e0 = n_fe_a;
      send_frame(128'hFF003F00, 4, 1'b0);
      chk("rm_busy_pre", busy_a, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rm_busy", busy_a, 0);
      chk("rm_pay", pay_a, 0);
      send_frame(128'h0FA08D7BAA, 5, 1'b0);
      idle(2);
      chk("rm_fv", n_fv_a - v0, 0);
      chk("rm_fe", n_fe_a - e0, 0);
      chk("rm_fc", fc_a, 0);

      // short frame, no checksum, 9600 baud
      v0 = n_fv_b; r0 = n_rxv_b;
      send_frame(128'hFF00123456AA, 6, 1'b1);
      repeat (2 * BPS_B) @(negedge clk);
      chk("b_rxv", n_rxv_b - r0, 6);
      chk("b_fv", n_fv_b - v0, 1);
      chk("b_pay", pay_b, 24'h123456);
      chk("b_fc", fc_b, 1);

      // 0.3-bit glitch on idle line
      r0 = n_rxv_b;
      rxd_b = 1'b0;
      repeat ((BPS_B * 3) / 10) @(negedge clk);
      rxd_b = 1'b1;
      repeat (12 * BPS_B) @(negedge clk);
      chk("b_glitch", n_rxv_b - r0, 0);
      chk("b_glitch_fe", fe_b, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
